// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//   - funct3 encodings for load/store size and sign
//   - FSM state encoding for mem_access_unit
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational access formatter.
//   rd_memory, wr_memory : operation type, used for legality only
//   funct3               : access size/sign
//   addr_lo              : address[1:0], byte lane selection
//   rs2_data             : store source data
//   rdata                : raw bus read word
//   wdata                : store data replicated across all lanes
//   be                   : byte enables for the access
//   load_ext             : selected and extended load result
//   misaligned           : access crosses its natural alignment
//   illegal              : funct3 invalid for the op, or rd and wr together
module mem_align
    import mem_access_pkg::*;
(
    input  logic        rd_memory,
    input  logic        wr_memory,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane picked by the low address bits; shift amount is lane * width.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    assign illegal = (rd_memory & wr_memory)
                   | (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)
                   | (wr_memory & funct3[2]);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        wdata      = 32'h0;
        be         = 4'b0000;
        load_ext   = 32'h0;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                wdata    = {4{rs2_data[7:0]}};
                be       = 4'b0001 << addr_lo;
                load_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                            : {24'h0, byte_sel};
            end
            F3_H, F3_HU: begin
                wdata      = {2{rs2_data[15:0]}};
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                load_ext   = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                wdata      = rs2_data;
                be         = 4'b1111;
                load_ext   = rdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns EX/MEM load/store requests into a req/ready bus
// handshake and stalls the pipeline until the access completes.
//   stg_clk, reset_n      : clock, async active-low reset
//   rd_memory, wr_memory  : load / store request
//   funct3_, address      : access size/sign, byte address
//   rs2_data              : store data
//   dmem_*                : registered bus request; dmem_ready/dmem_rdata return
//   load_data, load_valid : extended load result and its one-cycle strobe
//   mem_stall             : holds the upstream latch while an access is pending
//   err_misaligned/illegal: combinational fault flags (IDLE only)
//   err_bus               : one-cycle pulse when the bus times out
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        stg_clk,
    input  logic        reset_n,
    input  logic        rd_memory,
    input  logic        wr_memory,
    input  logic [2:0]  funct3_,
    input  logic [31:0] address,
    input  logic [31:0] rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_stall,
    output logic        err_misaligned,
    output logic        err_illegal,
    output logic        err_bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op;
    logic             start;
    logic [31:0]      fmt_wdata;
    logic [3:0]       fmt_be;
    logic [31:0]      load_ext;
    logic             misaligned;
    logic             illegal;

    // Upstream latch is frozen while stalled, so the live inputs stay valid
    // for load extraction throughout BUSY.
    mem_align u_align (
        .rd_memory  (rd_memory),
        .wr_memory  (wr_memory),
        .funct3     (funct3_),
        .addr_lo    (address[1:0]),
        .rs2_data   (rs2_data),
        .rdata      (dmem_rdata),
        .wdata      (fmt_wdata),
        .be         (fmt_be),
        .load_ext   (load_ext),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign op    = rd_memory | wr_memory;
    assign start = op & ~misaligned & ~illegal;

    // DONE drops the stall so the latch advances exactly once per access.
    assign mem_stall      = ((state == IDLE) & start) | (state == BUSY);
    assign err_misaligned = (state == IDLE) & op & misaligned;
    assign err_illegal    = (state == IDLE) & op & illegal;

    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'b0000;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            err_bus    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            load_valid <= 1'b0;
            err_bus    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= wr_memory;
                        dmem_addr  <= {address[31:2], 2'b00};
                        dmem_wdata <= wr_memory ? fmt_wdata : 32'h0;
                        dmem_be    <= fmt_be;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Ready takes priority over a coincident timeout.
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= load_ext;
                            load_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req <= 1'b0;
                        err_bus  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        stg_clk;
    logic        reset_n;
    logic        rd_memory;
    logic        wr_memory;
    logic [2:0]  funct3_;
    logic [31:0] address;
    logic [31:0] rs2_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_stall;
    logic        err_misaligned;
    logic        err_illegal;
    logic        err_bus;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .stg_clk        (stg_clk),
        .reset_n        (reset_n),
        .rd_memory      (rd_memory),
        .wr_memory      (wr_memory),
        .funct3_        (funct3_),
        .address        (address),
        .rs2_data       (rs2_data),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .mem_stall      (mem_stall),
        .err_misaligned (err_misaligned),
        .err_illegal    (err_illegal),
        .err_bus        (err_bus)
    );

    initial stg_clk = 1'b0;
    always #5 stg_clk = ~stg_clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_load_q[$];
    int          exp_bus_pending = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Bus responder configuration: ready in the Nth BUSY cycle, 0 = never.
    int          resp_delay = 1;
    logic [31:0] resp_data  = 32'h0;
    int          busy_n     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder
    initial begin
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(posedge stg_clk);
            #1;
            if (dmem_req) begin
                busy_n++;
                dmem_ready = (resp_delay != 0) && (busy_n == resp_delay);
                dmem_rdata = dmem_ready ? resp_data : 32'h0;
            end else begin
                busy_n     = 0;
                dmem_ready = 1'b0;
                dmem_rdata = 32'h0;
            end
        end
    end

    // Monitor / scoreboard
    logic req_prev = 1'b0;
    initial begin
        req_t e;
        logic [31:0] ld;
        forever begin
            @(negedge stg_clk);
            if (dmem_req && !req_prev) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", 32'(dmem_req), 32'h0);
                end else begin
                    e = exp_req_q.pop_front();
                    check("dmem_we",    32'(dmem_we), 32'(e.we));
                    check("dmem_addr",  dmem_addr,    e.addr);
                    check("dmem_wdata", dmem_wdata,   e.wdata);
                    check("dmem_be",    32'(dmem_be), 32'(e.be));
                end
            end
            req_prev = dmem_req;
            if (load_valid) begin
                if (exp_load_q.size() == 0) begin
                    check("unexpected_load_valid", 32'(load_valid), 32'h0);
                end else begin
                    ld = exp_load_q.pop_front();
                    check("load_data", load_data, ld);
                end
            end
            if (err_bus) begin
                check("err_bus_expected", 32'(exp_bus_pending > 0), 32'h1);
                if (exp_bus_pending > 0) exp_bus_pending--;
            end
        end
    end

    // Issue one op, hold it while stalled, and check stall length and fault flags.
    task automatic run_op(input string name, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int delay,
                          input logic [31:0] rdata, input int exp_stall,
                          input logic exp_mis, input logic exp_ill);
        int stall_cnt = 0;
        resp_delay = delay;
        resp_data  = rdata;
        @(posedge stg_clk);
        #1;
        rd_memory = rd;
        wr_memory = wr;
        funct3_   = f3;
        address   = addr;
        rs2_data  = rs2;
        @(negedge stg_clk);
        check({name, "_err_misaligned"}, 32'(err_misaligned), 32'(exp_mis));
        check({name, "_err_illegal"},    32'(err_illegal),    32'(exp_ill));
        for (int i = 0; i < 40; i++) begin
            if (!mem_stall) break;
            stall_cnt++;
            @(negedge stg_clk);
        end
        check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        @(posedge stg_clk);
        #1;
        rd_memory = 1'b0;
        wr_memory = 1'b0;
    endtask

    task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.be = be;
        exp_req_q.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        rd_memory = 1'b0;
        wr_memory = 1'b0;
        funct3_   = 3'b000;
        address   = 32'h0;
        rs2_data  = 32'h0;
        #12;
        check("rst_dmem_req",   32'(dmem_req),   32'h0);
        check("rst_dmem_addr",  dmem_addr,       32'h0);
        check("rst_load_valid", 32'(load_valid), 32'h0);
        check("rst_mem_stall",  32'(mem_stall),  32'h0);
        check("rst_err_bus",    32'(err_bus),    32'h0);
        @(negedge stg_clk);
        reset_n = 1'b1;

        // LW 0x100, ready in 2nd BUSY cycle: stall = IDLE + 2 BUSY
        push_req(1'b0, 32'h100, 32'h0, 4'b1111);
        exp_load_q.push_back(32'hDEADBEEF);
        run_op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 3, 0, 0);

        // LB / LBU 0x203, top byte 0x80
        push_req(1'b0, 32'h200, 32'h0, 4'b1000);
        exp_load_q.push_back(32'hFFFFFF80);
        run_op("lb", 1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80123456, 2, 0, 0);
        push_req(1'b0, 32'h200, 32'h0, 4'b1000);
        exp_load_q.push_back(32'h00000080);
        run_op("lbu", 1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h80123456, 2, 0, 0);

        // LB at byte 1, positive byte
        push_req(1'b0, 32'h0, 32'h0, 4'b0010);
        exp_load_q.push_back(32'h0000007F);
        run_op("lb1", 1, 0, 3'b000, 32'h1, 32'h0, 1, 32'h00007F00, 2, 0, 0);

        // LH / LHU upper half
        push_req(1'b0, 32'h4, 32'h0, 4'b1100);
        exp_load_q.push_back(32'hFFFF8001);
        run_op("lh", 1, 0, 3'b001, 32'h6, 32'h0, 3, 32'h80017FFF, 4, 0, 0);
        push_req(1'b0, 32'h4, 32'h0, 4'b1100);
        exp_load_q.push_back(32'h00008001);
        run_op("lhu", 1, 0, 3'b101, 32'h6, 32'h0, 1, 32'h80017FFF, 2, 0, 0);

        // Stores
        push_req(1'b1, 32'h100, 32'hBEEFBEEF, 4'b1100);
        run_op("sh", 0, 1, 3'b001, 32'h102, 32'h1234BEEF, 1, 32'h0, 2, 0, 0);
        push_req(1'b1, 32'h300, 32'hDDDDDDDD, 4'b0010);
        run_op("sb", 0, 1, 3'b000, 32'h301, 32'hAABBCCDD, 2, 32'h0, 3, 0, 0);
        push_req(1'b1, 32'h400, 32'h01234567, 4'b1111);
        run_op("sw", 0, 1, 3'b010, 32'h400, 32'h01234567, 1, 32'h0, 2, 0, 0);

        // Faulting ops: no request, no stall
        run_op("lw_mis",  1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 0, 1, 0);
        run_op("lh_mis",  1, 0, 3'b001, 32'h3,   32'h0, 1, 32'h0, 0, 1, 0);
        run_op("rdwr",    1, 1, 3'b010, 32'h0,   32'h0, 1, 32'h0, 0, 0, 1);
        run_op("sbu",     0, 1, 3'b100, 32'h0,   32'h0, 1, 32'h0, 0, 0, 1);
        run_op("f3_011",  1, 0, 3'b011, 32'h0,   32'h0, 1, 32'h0, 0, 0, 1);

        // Timeout: 16 BUSY cycles then err_bus
        push_req(1'b0, 32'h500, 32'h0, 4'b1111);
        exp_bus_pending++;
        run_op("timeout", 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0, 17, 0, 0);

        // Ready on the last BUSY cycle wins over timeout
        push_req(1'b0, 32'h600, 32'h0, 4'b1111);
        exp_load_q.push_back(32'h13579BDF);
        run_op("ready_last", 1, 0, 3'b010, 32'h600, 32'h0, 16, 32'h13579BDF, 17, 0, 0);

        // Async reset in the 2nd BUSY cycle
        push_req(1'b0, 32'h700, 32'h0, 4'b1111);
        resp_delay = 0;
        @(posedge stg_clk);
        #1;
        rd_memory = 1'b1;
        funct3_   = 3'b010;
        address   = 32'h700;
        @(posedge stg_clk);
        @(posedge stg_clk);
        #2;
        check("pre_rst_req", 32'(dmem_req), 32'h1);
        rd_memory = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("mid_rst_req",   32'(dmem_req),  32'h0);
        check("mid_rst_addr",  dmem_addr,      32'h0);
        check("mid_rst_be",    32'(dmem_be),   32'h0);
        check("mid_rst_stall", 32'(mem_stall), 32'h0);
        @(negedge stg_clk);
        reset_n = 1'b1;

        push_req(1'b0, 32'h800, 32'h0, 4'b0011);
        exp_load_q.push_back(32'hFFFFA5A5);
        run_op("post_rst_lh", 1, 0, 3'b001, 32'h800, 32'h0, 1, 32'h1234A5A5, 2, 0, 0);

        repeat (4) @(posedge stg_clk);
        @(negedge stg_clk);
        check("req_q_empty",  32'(exp_req_q.size()),  32'h0);
        check("load_q_empty", 32'(exp_load_q.size()), 32'h0);
        check("bus_pending",  32'(exp_bus_pending),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM address latch outputs: rd/wr strobe, funct3, effective address, rs2 store data.
- Converts each load/store into a request/ready handshake on the data-memory bus, with byte enables, store-data replication, load extraction and sign/zero extension.
- Raises a stall toward the hazard logic, which deasserts the latch enable until the access completes.
- Detects misaligned and illegal accesses, and bounds bus latency with a timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUSY cycles waiting for dmem_ready before aborting with a bus error.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- stg_clk  input  1  pipeline clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rd_memory  input  1  load request from the EX/MEM latch.
- wr_memory  input  1  store request from the EX/MEM latch.
- funct3_  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- address  input  32  byte effective address.
- rs2_data  input  32  store source data.
- dmem_req  output  1  bus request, registered.
- dmem_we  output  1  1 = write, registered.
- dmem_addr  output  32  word address, i.e. {address[31:2], 2'b00}, registered.
- dmem_wdata  output  32  replicated store data, registered.
- dmem_be  output  4  byte enables, registered.
- dmem_ready  input  1  bus accepts/completes the request this cycle.
- dmem_rdata  input  32  read word, valid when dmem_ready=1 and dmem_we=0.
- load_data  output  32  extended load result, registered.
- load_valid  output  1  one-cycle pulse; load_data is valid.
- mem_stall  output  1  combinational; freezes the upstream pipeline.
- err_misaligned  output  1  combinational; current access is misaligned.
- err_illegal  output  1  combinational; funct3 is invalid for the op, or rd and wr are both high.
- err_bus  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; all registered outputs 0; counter 0. Reset mid-BUSY drops dmem_req immediately.
- Definitions:
  - op = rd_memory | wr_memory.
  - misaligned = (W & address[1:0]≠0) | (H/HU & address[0]).
  - illegal = (rd & wr) | funct3 ∈ {011, 110, 111} | (wr & funct3[2]).
  - err_* outputs are asserted in IDLE only. A faulting op issues no request, gives mem_stall=0, and passes through in one cycle.
- IDLE:
  - If op & !misaligned & !illegal: mem_stall=1; next edge loads dmem_* registers, sets dmem_req=1, counter=0, and goes to BUSY.
  - Otherwise mem_stall=0.
- BUSY:
  - dmem_req and the other dmem_* signals are held stable; mem_stall=1.
  - On dmem_ready: dmem_req<=0; for loads, load_data<=formatted(dmem_rdata) and load_valid<=1; go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: dmem_req<=0, err_bus<=1, go to DONE.
  - Else counter++.
  - dmem_ready in the same cycle as the timeout: ready wins, no err_bus.
- DONE: mem_stall=0 so the latch advances on this edge; load_valid and err_bus clear next cycle; go to IDLE. No new request can start in DONE, which prevents re-issuing the same op.
- Latency: minimum 3 cycles per access (IDLE→BUSY, ready in the first BUSY cycle, DONE).
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, be=0001<<address[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=0011<<{address[1],1'b0}.
  - SW: wdata=rs2, be=1111.
- Loads: dmem_be is set as for stores and dmem_wdata=0. The byte or halfword is selected by address[1:0]; B/H are sign-extended, BU/HU zero-extended, W passes through.
- Address: dmem_addr is always word-aligned; low address bits are used only for be and select.
- dmem_ready while in IDLE or DONE is ignored.

Decomposition:
- Package mem_access_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding IDLE, BUSY, DONE (2 bits).
- Sub-module mem_align (combinational): funct3, address[1:0], rs2_data, rdata → wdata, be, load_ext, misaligned, illegal. Instantiated once in the FSM module.

Test Plan:
- LW at address 0x100, dmem_ready 2 cycles after req, rdata 0xDEADBEEF → dmem_addr=0x100, be=1111, mem_stall high 3 cycles, load_valid pulse with load_data=0xDEADBEEF.
- LB at 0x203, rdata 0x80123456 → be=1000, load_data=0xFFFFFF80; the same access as LBU gives load_data=0x00000080.
- SH at 0x102, rs2 0x1234BEEF → dmem_we=1, wdata=0xBEEFBEEF, be=1100, load_valid stays 0.
- LW at 0x101 → err_misaligned=1, dmem_req never asserts, mem_stall=0; rd & wr both high → err_illegal=1.
- dmem_ready never asserted → dmem_req drops after 16 BUSY cycles, err_bus pulses once, state returns to IDLE.
- reset_n low in the 2nd BUSY cycle → dmem_req=0 and all outputs 0 immediately, asynchronously; the next op after release issues normally.
